// File: rtl/rll_key_pkg.sv
// Shared types and constants for the RLL key loader.
package rll_key_pkg;

  localparam int KEY_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Counter must be able to hold KEY_W itself (saturation value).
  function automatic int cnt_width(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/rll_key_loader_if.sv
// Serial key link plus committed-key bus of the RLL key loader.
interface rll_key_loader_if #(
  parameter int KEY_W = rll_key_pkg::KEY_W_DEF
) ();

  logic             load_start;
  logic             key_clear;
  logic             key_valid;
  logic             key_bit;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_locked;
  logic             busy;
  logic             err;

  modport master (
    output load_start, key_clear, key_valid, key_bit,
    input  key_ready, key_out, key_locked, busy, err
  );

  modport slave (
    input  load_start, key_clear, key_valid, key_bit,
    output key_ready, key_out, key_locked, busy, err
  );

endinterface

// File: rtl/rll_key_shadow_sreg.sv
// Shadow register for the key under assembly: indexed bit write, clear,
// and running XOR of all bits written since the last clear.
module rll_key_shadow_sreg
  import rll_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int IDX_W = cnt_width(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_bit,
  output logic [KEY_W-1:0] o_shadow,
  output logic             o_parity
);

  logic [KEY_W-1:0] r_shadow;
  logic             r_par;

  // Each index is written at most once between clears (the caller's counter
  // only increments), so toggling by the written bit tracks XOR of the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_par    <= 1'b0;
    end else if (i_clr) begin
      r_shadow <= '0;
      r_par    <= 1'b0;
    end else if (i_we) begin
      for (int unsigned i = 0; i < KEY_W; i++) begin
        if (i_idx == IDX_W'(i)) r_shadow[i] <= i_bit;
      end
      if (i_idx < IDX_W'(KEY_W)) r_par <= r_par ^ i_bit;
    end
  end

  assign o_shadow = r_shadow;
  assign o_parity = r_par;

endmodule

// File: rtl/rll_key_loader.sv
// Serial-in key loader with atomic commit onto the parallel key bus feeding
// an RLL-locked netlist. Define RLL_KEY_PARITY_EN to require a trailing
// even-parity bit after the key bits.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] RESET_KEY = '0
) (
  input logic               clk,
  input logic               rst,
  rll_key_loader_if.slave   bus
);

  localparam int CNT_W = cnt_width(KEY_W);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_locked;
  logic [KEY_W-1:0] w_shadow;
  logic             w_ready;
  logic             w_beat;
  logic             w_start;
  logic             w_shift_beat;
  logic             w_last;

  assign w_ready      = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
  assign w_beat       = bus.key_valid && w_ready;
  assign w_start      = bus.load_start && (r_state != ST_COMMIT);
  assign w_shift_beat = w_beat && (r_state == ST_SHIFT) && !w_start;
  assign w_last       = (r_cnt == CNT_W'(KEY_W - 1));

`ifdef RLL_KEY_PARITY_EN
  logic w_parity;
  logic w_par_beat;
  logic w_par_ok;
  logic r_err;

  assign w_par_beat = w_beat && (r_state == ST_PARITY) && !w_start;
  assign w_par_ok   = ~(w_parity ^ bus.key_bit);

  // Sticky parity failure, cleared by an accepted load_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_err <= 1'b0;
    else if (w_start)                 r_err <= 1'b0;
    else if (w_par_beat && !w_par_ok) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // Load FSM: restart wins over a beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.load_start) r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_start) r_state <= ST_SHIFT;
`ifdef RLL_KEY_PARITY_EN
          else if (w_shift_beat && w_last) r_state <= ST_PARITY;
`else
          else if (w_shift_beat && w_last) r_state <= ST_COMMIT;
`endif
        end
        ST_PARITY: begin
`ifdef RLL_KEY_PARITY_EN
          if (w_start)         r_state <= ST_SHIFT;
          else if (w_par_beat) r_state <= w_par_ok ? ST_COMMIT : ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_COMMIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Beat counter, saturating at KEY_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_cnt <= '0;
    else if (w_start)                                 r_cnt <= '0;
    else if (w_shift_beat && r_cnt != CNT_W'(KEY_W)) r_cnt <= r_cnt + CNT_W'(1);
  end

  rll_key_shadow_sreg #(
    .KEY_W (KEY_W),
    .IDX_W (CNT_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_start),
    .i_we     (w_shift_beat),
    .i_idx    (r_cnt),
    .i_bit    (bus.key_bit),
    .o_shadow (w_shadow),
`ifdef RLL_KEY_PARITY_EN
    .o_parity (w_parity)
`else
    .o_parity ()
`endif
  );

  // Commit register: clear has priority over a same-cycle commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_out <= RESET_KEY;
      r_locked  <= 1'b0;
    end else if (bus.key_clear) begin
      r_key_out <= RESET_KEY;
      r_locked  <= 1'b0;
    end else if (r_state == ST_COMMIT) begin
      r_key_out <= w_shadow;
      r_locked  <= 1'b1;
    end
  end

  assign bus.key_ready  = w_ready;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.key_out    = r_key_out;
  assign bus.key_locked = r_locked;

endmodule

// File: tb/tb_rll_key_loader.sv
// Randomized bench for rll_key_loader against a transaction-level model of
// the committed key. Honours RLL_KEY_PARITY_EN like the design.
module tb_rll_key_loader;

  localparam int KEY_W = 32;
`ifdef RLL_KEY_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  rll_key_loader_if #(.KEY_W(KEY_W)) bus ();

  rll_key_loader #(
    .KEY_W     (KEY_W),
    .RESET_KEY ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [KEY_W-1:0] exp_key    = '0;
  logic             exp_locked = 1'b0;
  logic             exp_err    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag);
    check_eq({tag, "_key"}, bus.key_out, exp_key);
    check_eq({tag, "_locked"}, 32'(bus.key_locked), 32'(exp_locked));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_key"}, bus.key_out, exp_key);
    check_eq({tag, "_locked"}, 32'(bus.key_locked), 32'(exp_locked));
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.key_ready), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'(exp_err));
  endtask

  // One load transaction. abort_at >= 0 stops after that many beats, leaving
  // the loader mid-SHIFT. Gap percentage gives idle cycles between beats.
  task automatic do_load(input logic [KEY_W-1:0] key, input int gap, input int abort_at,
                         input logic pbit, input bit clr_in_commit, input bit start_in_commit);
    int nbeats;
    bit par_fail;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    exp_err = 1'b0;
    check_eq("start_ready", 32'(bus.key_ready), 32'd1);
    check_hold("start");
    nbeats = (abort_at >= 0) ? abort_at : KEY_W + PAR_BEATS;
    for (int k = 0; k < nbeats; k++) begin
      while (int'($urandom_range(99)) < gap) begin
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'($urandom);
        tick();
        check_eq("gap_ready", 32'(bus.key_ready), 32'd1);
        check_hold("gap");
      end
      bus.key_valid = 1'b1;
      bus.key_bit   = (k < KEY_W) ? key[k] : pbit;
      check_eq("beat_ready", 32'(bus.key_ready), 32'd1);
      tick();
      bus.key_valid = 1'b0;
      if (k < nbeats - 1) check_hold("shift");
    end
    if (abort_at >= 0) return;
    par_fail = (PAR_BEATS != 0) && ((^key ^ pbit) != 1'b0);
    if (par_fail) begin
      exp_err = 1'b1;
      check_idle("parfail");
      return;
    end
    check_hold("commit");
    check_eq("commit_ready", 32'(bus.key_ready), 32'd0);
    bus.key_clear  = clr_in_commit;
    bus.load_start = start_in_commit;
    tick();
    bus.key_clear  = 1'b0;
    bus.load_start = 1'b0;
    if (clr_in_commit) begin
      exp_key    = '0;
      exp_locked = 1'b0;
    end else begin
      exp_key    = key;
      exp_locked = 1'b1;
    end
    check_idle("done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] k;
    bus.load_start = 1'b0;
    bus.key_clear  = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_bit    = 1'b0;
    #3;
    check_idle("in_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle10");
    end

    do_load(32'hA5A5_0F0F, 0, -1, ^32'hA5A5_0F0F, 1'b0, 1'b0);
    do_load(32'hA5A5_0F0F, 50, -1, ^32'hA5A5_0F0F, 1'b0, 1'b0);

    k = $urandom;
    do_load(k, 0, 12, ^k, 1'b0, 1'b0);
    do_load(32'h1234_5678, 0, -1, ^32'h1234_5678, 1'b0, 1'b0);

    do_load(32'hFFFF_FFFF, 0, -1, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      k = $urandom;
      do_load(k, int'($urandom_range(50)), -1, ^k, ($urandom_range(3) == 0),
              ($urandom_range(3) == 0));
    end

    k = $urandom | 32'h1;
    do_load(k, 0, -1, ^k, 1'b0, 1'b0);
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    exp_key    = '0;
    exp_locked = 1'b0;
    check_idle("idle_clear");

    do_load(32'hC3C3_3C3C, 0, -1, ^32'hC3C3_3C3C, 1'b0, 1'b0);
    k = $urandom;
    do_load(k, 20, 10, ^k, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    exp_key    = '0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle("post_rst");

`ifdef RLL_KEY_PARITY_EN
    do_load(32'h0000_0001, 0, -1, 1'b0, 1'b0, 1'b0);
    check_eq("par_err_set", 32'(bus.err), 32'd1);
    do_load(32'h0000_0001, 0, -1, 1'b1, 1'b0, 1'b0);
    check_eq("par_key", bus.key_out, 32'h0000_0001);
`endif

    repeat (3) tick();
    check_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
